// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ
// requesters. A requester is granted in IDLE (one bubble cycle), then owns the
// write port in BURST until it sends a word with last set, reaches MAX_BURST
// beats, or drops valid. FIFO full stalls the burst without losing the grant.
// Every written word is tagged with the id of its source requester.
//
// Optional feature macro: FIFO_ARB_STATS_EN
//   When defined, adds per-requester saturating grant counters, the CNT_W
//   parameter and the stat_clr / stat_grant_cnt ports.
//
// Ports
//   sys_clk         in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   req_valid       in   [NUM_REQ]        requester i has a word
//   req_last        in   [NUM_REQ]        requester i word ends its packet
//   req_data        in   [NUM_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   req_ready       out  [NUM_REQ]        requester i word accepted this cycle
//   fifo_full       in   FIFO full (combinational from FIFO pointers)
//   fifo_wr_en      out  FIFO write strobe
//   fifo_wr_data    out  [WIDTH]          word to FIFO
//   fifo_wr_src     out  [ID_W]           id of the requester owning the word
//   arb_busy        out  high while a burst is in progress
//   stat_clr        in   (stats only) synchronous clear of all counters
//   stat_grant_cnt  out  (stats only) [NUM_REQ*CNT_W] bursts granted per requester
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
`ifdef FIFO_ARB_STATS_EN
  parameter int CNT_W     = 16,
`endif
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]          fifo_wr_src,
  output logic                     arb_busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ*CNT_W-1:0] stat_grant_cnt
`endif
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [ID_W-1:0]   pick;
  logic              found;
  int                scan_idx;
  logic              xfer;
  logic              burst_end;

  // Unpacked view of the flat data bus so the granted word is a plain index.
  logic [WIDTH-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester scanning rr_q, rr_q+1, ... wrapping.
  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    pick     = rr_q;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && req_valid[ID_W'(scan_idx)]) begin
        pick  = ID_W'(scan_idx);
        found = 1'b1;
      end
    end
  end

  // Next state and outputs. Outputs depend only on state and inputs, so an
  // async reset forces them all to zero in the same cycle.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    beat_d       = beat_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    fifo_wr_src  = '0;
    arb_busy     = 1'b0;
    xfer         = 1'b0;
    burst_end    = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        arb_busy         = 1'b1;
        fifo_wr_src      = gnt_q;
        fifo_wr_data     = data_arr[gnt_q];
        req_ready[gnt_q] = !fifo_full;
        xfer             = req_valid[gnt_q] && !fifo_full;
        fifo_wr_en       = xfer;

        if (!req_valid[gnt_q]) begin
          // Requester withdrew: release the grant without writing.
          burst_end = 1'b1;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (req_last[gnt_q] || beat_q == LAST_BEAT) burst_end = 1'b1;
        end
        // fifo_full with valid held: stall, gnt_q and beat_q unchanged.

        if (burst_end) begin
          state_d = IDLE;
          rr_d    = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic             grant_evt;
  logic [CNT_W-1:0] grant_cnt [NUM_REQ];

  assign grant_evt = (state_q == IDLE) && found;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset element by element; it is a small register bank, not RAM.
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          grant_cnt[i] <= '0;
        end else if (grant_evt && pick == ID_W'(i) && grant_cnt[i] != '1) begin
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_grant_cnt[i*CNT_W +: CNT_W] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=32, MAX_BURST=4).
// Each requester is a queue of words presented with valid/last; a word is
// popped after the edge on which valid & ready held. Tests push the expected
// (source id, data) write sequence into a scoreboard; a monitor pops and
// compares on every fifo_wr_en. Write cycle stamps check burst timing.
// With FIFO_ARB_STATS_EN defined, a second instance (CNT_W=2) checks saturation.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } word_t;

  typedef struct {
    logic [ID_W-1:0]  src;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                     sys_clk = 1'b0;
  logic                     rst_n   = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_last  = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic [ID_W-1:0]          fifo_wr_src;
  logic                     arb_busy;

  word_t src_q [NUM_REQ][$];
  exp_t  exp_q [$];
  int    wr_stamp [$];
  int    cyc          = 0;
  int    tests_run    = 0;
  int    tests_failed = 0;

`ifdef FIFO_ARB_STATS_EN
  logic                     stat_clr = 1'b0;
  logic [NUM_REQ*16-1:0]    stat_grant_cnt;
  logic [NUM_REQ*2-1:0]     sat_grant_cnt;
  logic [NUM_REQ-1:0]       sat_ready;
  logic                     sat_wr_en;
  logic [WIDTH-1:0]         sat_wr_data;
  logic [ID_W-1:0]          sat_wr_src;
  logic                     sat_busy;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
`ifdef FIFO_ARB_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_src  (fifo_wr_src),
    .arb_busy     (arb_busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

`ifdef FIFO_ARB_STATS_EN
  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .CNT_W(2)
  ) dut_sat (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (sat_ready),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (sat_wr_en),
    .fifo_wr_data   (sat_wr_data),
    .fifo_wr_src    (sat_wr_src),
    .arb_busy       (sat_busy),
    .stat_clr       (stat_clr),
    .stat_grant_cnt (sat_grant_cnt)
  );
`endif

  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------- helpers
  task automatic push_word(input int r, input logic [WIDTH-1:0] d, input logic last);
    word_t w;
    w.data = d;
    w.last = last;
    src_q[r].push_back(w);
  endtask

  task automatic push_exp(input int r, input logic [WIDTH-1:0] d);
    exp_t e;
    e.src  = ID_W'(r);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]                = 1'b1;
        req_last[i]                 = src_q[i][0].last;
        req_data[i*WIDTH +: WIDTH]  = src_q[i][0].data;
      end else begin
        req_valid[i]                = 1'b0;
        req_last[i]                 = 1'b0;
        req_data[i*WIDTH +: WIDTH]  = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #3;
    rst_n = 1'b0;
    @(posedge sys_clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && (exp_q.size() != 0 || pending() != 0 || arb_busy)) begin
      @(negedge sys_clk); #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0 || pending() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d writes still expected, %0d words unsent; required 0 and 0",
               name, exp_q.size(), pending());
    end
  endtask

  task automatic check_gaps(input string name, input int gaps[$]);
    tests_run++;
    if (wr_stamp.size() != gaps.size() + 1) begin
      tests_failed++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, wr_stamp.size(), gaps.size() + 1);
    end else begin
      for (int k = 0; k < gaps.size(); k++) begin
        tests_run++;
        if (wr_stamp[k+1] - wr_stamp[k] !== gaps[k]) begin
          tests_failed++;
          $display("FAIL %s_gap%0d: got %0d cycles, required %0d",
                   name, k, wr_stamp[k+1] - wr_stamp[k], gaps[k]);
        end
      end
    end
  endtask

  // ------------------------------------------------- requester model + monitor
  initial begin
    logic [NUM_REQ-1:0] hs;
    drive_reqs();
    forever begin
      @(negedge sys_clk);
      hs = req_valid & req_ready;
      if (fifo_wr_en) begin
        wr_stamp.push_back(cyc);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: got src %0d data %h, required no write", fifo_wr_src, fifo_wr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (fifo_wr_src !== e.src || fifo_wr_data !== e.data) begin
            tests_failed++;
            $display("FAIL write_word: got src %0d data %h, required src %0d data %h",
                     fifo_wr_src, fifo_wr_data, e.src, e.data);
          end
        end
      end
      @(posedge sys_clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_reqs();
    end
  end

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    int n = 0;
    #2;
    tests_run++;
    if ({arb_busy, fifo_wr_en, req_ready, fifo_wr_src} !== '0 || fifo_wr_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b wr_en=%b ready=%b src=%0d, required all 0",
               arb_busy, fifo_wr_en, req_ready, fifo_wr_src);
    end
    @(posedge sys_clk); #3;
    rst_n = 1'b1;

    // Grant req2 while the FIFO is full, then free the FIFO and reset mid-burst.
    fifo_full = 1'b1;
    @(negedge sys_clk);
    push_word(2, 32'h2222_0000, 1'b0);
    push_word(2, 32'h2222_0001, 1'b1);
    push_exp(2, 32'h2222_0000);
    push_exp(2, 32'h2222_0001);
    while (!arb_busy && n < 20) begin
      @(negedge sys_clk); #1;
      n++;
    end
    tests_run++;
    if (arb_busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_grant: got busy=%b wr_en=%b, required busy=1 wr_en=0", arb_busy, fifo_wr_en);
    end
    @(posedge sys_clk); #1;
    fifo_full = 1'b0;
    #1;
    tests_run++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_src !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_reset_write: got wr_en=%b src=%0d, required wr_en=1 src=2", fifo_wr_en, fifo_wr_src);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({arb_busy, fifo_wr_en, req_ready, fifo_wr_src} !== '0 || fifo_wr_data !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b wr_en=%b ready=%b src=%0d, required all 0",
               arb_busy, fifo_wr_en, req_ready, fifo_wr_src);
    end
    @(posedge sys_clk); #3;
    rst_n = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (arb_busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got busy=%b wr_en=%b, required 0 0", arb_busy, fifo_wr_en);
    end
    @(negedge sys_clk);
    tests_run++;
    if (fifo_wr_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_latency: got wr_en=%b, required 1", fifo_wr_en);
    end
    wait_drain("reset", 50);
  endtask

  task automatic test_round_robin();
    wr_stamp.delete();
    @(negedge sys_clk);
    push_word(0, 32'h0A00_0000, 1'b1);
    push_word(1, 32'h0A10_0000, 1'b1);
    push_word(2, 32'h0A20_0000, 1'b1);
    push_word(3, 32'h0A30_0000, 1'b1);
    push_word(0, 32'h0A01_0000, 1'b1);
    push_exp(0, 32'h0A00_0000);
    push_exp(1, 32'h0A10_0000);
    push_exp(2, 32'h0A20_0000);
    push_exp(3, 32'h0A30_0000);
    push_exp(0, 32'h0A01_0000);
    wait_drain("round_robin", 100);
    check_gaps("round_robin", '{2, 2, 2, 2});
  endtask

  task automatic test_burst_cap();
    wr_stamp.delete();
    @(negedge sys_clk);
    for (int k = 0; k < 10; k++) begin
      push_word(0, 32'hB000_0000 + k, 1'b0);
      push_exp(0, 32'hB000_0000 + k);
    end
    wait_drain("burst_cap", 100);
    check_gaps("burst_cap", '{1, 1, 1, 2, 1, 1, 1, 2, 1});
  endtask

  task automatic test_full_stall();
    int n = 0;
    wr_stamp.delete();
    @(negedge sys_clk);
    for (int k = 0; k < 5; k++) begin
      push_word(1, 32'hC100_0000 + k, 1'b0);
      push_exp(1, 32'hC100_0000 + k);
    end
    while (wr_stamp.size() < 1 && n < 20) begin
      @(negedge sys_clk); #1;
      n++;
    end
    @(posedge sys_clk); #1;
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      tests_run++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0 || arb_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got ready=%b wr_en=%b busy=%b, required 0000 0 1",
                 k, req_ready, fifo_wr_en, arb_busy);
      end
    end
    @(posedge sys_clk); #1;
    fifo_full = 1'b0;
    wait_drain("full_stall", 100);
    // Beat count survives the stall: 3 more beats close the first burst.
    check_gaps("full_stall", '{4, 1, 1, 2});
  endtask

  task automatic test_fairness();
    @(negedge sys_clk);
    push_word(1, 32'hD100_0000, 1'b1);
    push_exp(1, 32'hD100_0000);
    wait_drain("fair_setup", 50);
    wr_stamp.delete();
    @(negedge sys_clk);
    push_word(3, 32'hD300_0000, 1'b0);
    push_word(3, 32'hD300_0001, 1'b0);
    push_word(1, 32'hD100_0001, 1'b1);
    push_exp(3, 32'hD300_0000);
    push_exp(3, 32'hD300_0001);
    push_exp(1, 32'hD100_0001);
    wait_drain("fairness", 100);
    // req3 drops valid: one release cycle plus one IDLE cycle before req1.
    check_gaps("fairness", '{1, 3});
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    logic [NUM_REQ*16-1:0] exp_cnt;
    logic [NUM_REQ*2-1:0]  exp_sat;
    @(negedge sys_clk);
    for (int k = 0; k < 5; k++) begin
      push_word(2, 32'hE200_0000 + k, 1'b1);
      push_exp(2, 32'hE200_0000 + k);
    end
    wait_drain("stats", 100);
    exp_cnt = '0;
    exp_cnt[2*16 +: 16] = 16'd5;
    exp_sat = '0;
    exp_sat[2*2 +: 2] = 2'd3;
    tests_run++;
    if (stat_grant_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL stat_count: got %h, required %h", stat_grant_cnt, exp_cnt);
    end
    tests_run++;
    if (sat_grant_cnt !== exp_sat) begin
      tests_failed++;
      $display("FAIL stat_saturate: got %h, required %h", sat_grant_cnt, exp_sat);
    end
    @(posedge sys_clk); #1;
    stat_clr = 1'b1;
    @(posedge sys_clk); #1;
    stat_clr = 1'b0;
    tests_run++;
    if (stat_grant_cnt !== '0 || sat_grant_cnt !== '0) begin
      tests_failed++;
      $display("FAIL stat_clear: got %h / %h, required 0 / 0", stat_grant_cnt, sat_grant_cnt);
    end
  endtask
`endif

  initial begin
    #1;
    rst_n = 1'b0;
    test_reset();
    do_reset();
    test_round_robin();
    do_reset();
    test_burst_cap();
    do_reset();
    test_full_stall();
    do_reset();
    test_fairness();
`ifdef FIFO_ARB_STATS_EN
    do_reset();
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
